// File: rtl/ptw_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ptw_arb_pkg
// Description : Shared widths, FSM state encoding and helpers for the PTW
//               arbiter and its round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package ptw_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int PTE_W  = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RET   = 2'd3;

    // Index width for n requesters; a single-requester build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request at or
//               after ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = ptw_arb_pkg::idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [IDX_W:0] c_num = (IDX_W+1)'(N);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_rot_idx;
    logic [IDX_W:0]   w_sum;

    // Rotate so that requester ptr lands at bit 0.
    assign w_rot = N'({req, req} >> ptr);

    always_comb begin
        grant_valid = 1'b0;
        w_rot_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                grant_valid = 1'b1;
                w_rot_idx   = IDX_W'(k);
            end
        end
    end

    assign w_sum     = {1'b0, w_rot_idx} + {1'b0, ptr};
    assign grant_idx = (w_sum >= c_num) ? IDX_W'(w_sum - c_num) : w_sum[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ptw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ptw_arbiter
// Description : Shares one page-table walker between NUM_REQ TLBs, one walk
//               in flight, round-robin grant, PTE routed back to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ptw_arb_pkg::ADDR_W,
    parameter int PTE_W   = ptw_arb_pkg::PTE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_vaddr_i,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    input  logic [NUM_REQ-1:0]        resp_ready_i,
    output logic [PTE_W-1:0]          resp_pte_o,
    output logic                      ptw_req_valid_o,
    input  logic                      ptw_req_ready_i,
    output logic [ADDR_W-1:0]         ptw_vaddr_o,
    input  logic                      ptw_resp_valid_i,
    output logic                      ptw_resp_ready_o,
    input  logic [PTE_W-1:0]          ptw_pte_i,
    output logic                      busy_o
);

    import ptw_arb_pkg::*;

    localparam int IDX_W = ptw_arb_pkg::idx_width(NUM_REQ);
    localparam logic [IDX_W:0] c_num_req = (IDX_W+1)'(NUM_REQ);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] r_vaddr;
    logic [PTE_W-1:0]  r_pte;

    logic              w_grant_valid;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [ADDR_W-1:0] w_vaddr_arr [NUM_REQ];
    logic [IDX_W:0]    w_owner_inc;
    logic [IDX_W-1:0]  w_owner_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_vaddr
            assign w_vaddr_arr[gi] = req_vaddr_i[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (req_valid_i),
        .ptr         (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Next round-robin start is the port after the finishing owner.
    assign w_owner_inc  = {1'b0, r_owner} + {{IDX_W{1'b0}}, 1'b1};
    assign w_owner_next = (w_owner_inc == c_num_req) ? '0 : w_owner_inc[IDX_W-1:0];

    always_comb begin
        req_ready_o      = '0;
        resp_valid_o     = '0;
        ptw_req_valid_o  = 1'b0;
        ptw_resp_ready_o = 1'b0;
        case (r_state)
            S_IDLE:  if (w_grant_valid) req_ready_o[w_grant_idx] = 1'b1;
            S_ISSUE: ptw_req_valid_o  = 1'b1;
            S_WAIT:  ptw_resp_ready_o = 1'b1;
            S_RET:   resp_valid_o[r_owner] = 1'b1;
            default: ;
        endcase
    end

    assign ptw_vaddr_o = r_vaddr;
    assign resp_pte_o  = r_pte;
    assign busy_o      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_vaddr  <= '0;
            r_pte    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_idx;
                        r_vaddr <= w_vaddr_arr[w_grant_idx];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ptw_req_ready_i) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ptw_resp_valid_i) begin
                        r_pte   <= ptw_pte_i;
                        r_state <= S_RET;
                    end
                end
                S_RET: begin
                    if (resp_ready_i[r_owner]) begin
                        r_rr_ptr <= w_owner_next;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
